stack_sequencer: RTL and testbench

Multi-cycle stack engine that is the initiator side of the register bank port. It executes PUSH/POP/CALL/RET and interrupt entry by reading and writing R0-R7 and SP through the bank's read/write selects, and by driving data memory. It sits between the control unit (commands, PC) and the register bank / data memory. It owns all SP updates while busy; nothing else writes SP while a command is in flight.

---
 rtl/stack_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_stack_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Stack engine driving the register bank and data memory for PUSH/POP/CALL/RET
// and interrupt entry; owns every SP update while a command is in flight.
module stack_sequencer #(
  parameter int               DATA_W      = 16,
  parameter int               ADDR_W      = 12,
  parameter logic [3:0]       SP_SEL      = 4'd8,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 12'hF00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_target,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              irq,
  output logic              irq_ack,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [ADDR_W-1:0] isr_in,
  output logic [3:0]        rb_read_sel,
  input  logic [DATA_W-1:0] rb_read_data,
  output logic              rb_write_en,
  output logic [3:0]        rb_write_sel,
  output logic [DATA_W-1:0] rb_write_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              done,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int PAD = DATA_W - ADDR_W;

  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_t;

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_POP_RD, S_POP_WB, S_POP_SP, S_CALL, S_RET_RD, S_RET_WB, S_ERR
  } state_t;

  typedef struct packed {
    logic [2:0]        rsel;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc;
    logic              is_irq;
    logic              ovf;
    logic              unf;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd_q;

  logic              at_limit, at_empty;
  logic [ADDR_W-1:0] sp_dec, sp_inc;

  assign at_limit = (sp_in == STACK_LIMIT);
  assign at_empty = (sp_in == '0);
  assign sp_dec   = sp_in - 1'b1;
  assign sp_inc   = sp_in + 1'b1;

  // Latch the command at accept; irq wins over cmd_valid and vectors through isr_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cmd_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (irq) begin
          cmd_q.rsel   <= '0;
          cmd_q.tgt    <= isr_in;
          cmd_q.pc     <= pc_in;
          cmd_q.is_irq <= 1'b1;
          cmd_q.ovf    <= at_limit;
          cmd_q.unf    <= 1'b0;
        end else if (cmd_valid) begin
          cmd_q.rsel   <= cmd_reg;
          cmd_q.tgt    <= cmd_target;
          cmd_q.pc     <= pc_in;
          cmd_q.is_irq <= 1'b0;
          cmd_q.ovf    <= at_limit && (cmd_op == OP_PUSH || cmd_op == OP_CALL);
          cmd_q.unf    <= at_empty && (cmd_op == OP_POP  || cmd_op == OP_RET);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (irq) begin
          state_nxt = at_limit ? S_ERR : S_CALL;
        end else if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_PUSH: state_nxt = at_limit ? S_ERR : S_PUSH;
            OP_POP:  state_nxt = at_empty ? S_ERR : S_POP_RD;
            OP_CALL: state_nxt = at_limit ? S_ERR : S_CALL;
            default: state_nxt = at_empty ? S_ERR : S_RET_RD;
          endcase
        end
      end
      S_POP_RD: state_nxt = S_POP_WB;
      S_POP_WB: state_nxt = S_POP_SP;
      S_RET_RD: state_nxt = S_RET_WB;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // All strobes decode from the registered state so a reset drops any pending write.
  always_comb begin
    cmd_ready     = 1'b0;
    irq_ack       = 1'b0;
    rb_read_sel   = 4'd0;
    rb_write_en   = 1'b0;
    rb_write_sel  = 4'd0;
    rb_write_data = '0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    mem_re        = 1'b0;
    pc_load       = 1'b0;
    pc_next       = '0;
    done          = 1'b0;
    ovf_err       = 1'b0;
    unf_err       = 1'b0;
    case (state)
      S_IDLE: cmd_ready = ~irq;
      S_PUSH: begin
        rb_read_sel   = {1'b0, cmd_q.rsel};
        mem_we        = 1'b1;
        mem_addr      = sp_dec;
        mem_wdata     = rb_read_data;
        rb_write_en   = 1'b1;
        rb_write_sel  = SP_SEL;
        rb_write_data = {{PAD{1'b0}}, sp_dec};
        done          = 1'b1;
      end
      S_POP_RD, S_RET_RD: begin
        mem_re   = 1'b1;
        mem_addr = sp_in;
      end
      S_POP_WB: begin
        rb_write_en   = 1'b1;
        rb_write_sel  = {1'b0, cmd_q.rsel};
        rb_write_data = mem_rdata;
      end
      S_POP_SP: begin
        rb_write_en   = 1'b1;
        rb_write_sel  = SP_SEL;
        rb_write_data = {{PAD{1'b0}}, sp_inc};
        done          = 1'b1;
      end
      S_CALL: begin
        mem_we        = 1'b1;
        mem_addr      = sp_dec;
        mem_wdata     = {{PAD{1'b0}}, cmd_q.pc};
        rb_write_en   = 1'b1;
        rb_write_sel  = SP_SEL;
        rb_write_data = {{PAD{1'b0}}, sp_dec};
        pc_load       = 1'b1;
        pc_next       = cmd_q.tgt;
        done          = 1'b1;
        irq_ack       = cmd_q.is_irq;
      end
      S_RET_WB: begin
        pc_load       = 1'b1;
        pc_next       = mem_rdata[ADDR_W-1:0];
        rb_write_en   = 1'b1;
        rb_write_sel  = SP_SEL;
        rb_write_data = {{PAD{1'b0}}, sp_inc};
        done          = 1'b1;
      end
      S_ERR: begin
        done    = 1'b1;
        ovf_err = cmd_q.ovf;
        unf_err = cmd_q.unf;
        irq_ack = cmd_q.is_irq;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: stimulus queues hand-computed expectations,
// a monitor gathers each command's bank/memory/PC effects and checks them on done.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, irq, irq_ack;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_reg;
  logic [11:0] cmd_target, pc_in, sp_in, isr_in, mem_addr, pc_next;
  logic [3:0]  rb_read_sel, rb_write_sel;
  logic [15:0] rb_read_data, rb_write_data, mem_wdata, mem_rdata;
  logic        rb_write_en, mem_we, mem_re, pc_load, done, ovf_err, unf_err;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_target(cmd_target), .pc_in(pc_in),
    .irq(irq), .irq_ack(irq_ack), .sp_in(sp_in), .isr_in(isr_in),
    .rb_read_sel(rb_read_sel), .rb_read_data(rb_read_data), .rb_write_en(rb_write_en),
    .rb_write_sel(rb_write_sel), .rb_write_data(rb_write_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .pc_load(pc_load), .pc_next(pc_next), .done(done), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // Register bank and memory environment; pokes preload state while the engine is idle.
  logic [15:0] regs [8];
  logic [15:0] mem  [4096];
  logic [11:0] sp;
  int          cyc;
  logic        pk_en, pk_mem;
  logic [11:0] pk_idx;
  logic [15:0] pk_val;

  assign sp_in = sp;
  always_comb begin
    rb_read_data = 16'd0;
    if (rb_read_sel < 4'd8)       rb_read_data = regs[rb_read_sel[2:0]];
    else if (rb_read_sel == 4'd8) rb_read_data = {4'd0, sp};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pk_en) begin
      if (pk_mem)              mem[pk_idx] <= pk_val;
      else if (pk_idx == 12'd8) sp <= pk_val[11:0];
      else                     regs[pk_idx[2:0]] <= pk_val;
    end else begin
      if (rb_write_en) begin
        if (rb_write_sel == 4'd8)     sp <= rb_write_data[11:0];
        else if (rb_write_sel < 4'd8) regs[rb_write_sel[2:0]] <= rb_write_data;
      end
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    string       name;
    int          t;
    int          lat;
    bit          ovf, unf, ack, mw, spw, rw, pl;
    logic [11:0] ma, spv, pn;
    logic [15:0] md, rv;
    logic [2:0]  ri;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input int lat, input bit ovf, input bit unf,
                              input bit ack, input bit mw, input logic [11:0] ma,
                              input logic [15:0] md, input bit spw, input logic [11:0] spv,
                              input bit rw, input logic [2:0] ri, input logic [15:0] rv,
                              input bit pl, input logic [11:0] pn);
    exp_t e;
    e.name = n; e.t = 0; e.lat = lat; e.ovf = ovf; e.unf = unf; e.ack = ack;
    e.mw = mw; e.ma = ma; e.md = md; e.spw = spw; e.spv = spv;
    e.rw = rw; e.ri = ri; e.rv = rv; e.pl = pl; e.pn = pn;
    return e;
  endfunction

  // Monitor: accumulate effects per command, compare on done.
  int          mw_n, spw_n, rw_n, pl_n, ack_n;
  logic [11:0] o_ma, o_spv, o_pn;
  logic [15:0] o_md, o_rv;
  logic [2:0]  o_ri;
  bit          rdy_chk;

  initial begin
    exp_t e;
    mw_n = 0; spw_n = 0; rw_n = 0; pl_n = 0; ack_n = 0; rdy_chk = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mw_n = 0; spw_n = 0; rw_n = 0; pl_n = 0; ack_n = 0; rdy_chk = 0;
      end else begin
        if (rdy_chk) begin
          rdy_chk = 0;
          if (!irq) chk("ready_after_done", cmd_ready, 1);
        end
        if (mem_we) begin mw_n++; o_ma = mem_addr; o_md = mem_wdata; end
        if (rb_write_en && rb_write_sel == 4'd8) begin spw_n++; o_spv = rb_write_data[11:0]; end
        if (rb_write_en && rb_write_sel != 4'd8) begin rw_n++; o_ri = rb_write_sel[2:0]; o_rv = rb_write_data; end
        if (pl_n == 0 && pc_load) o_pn = pc_next;
        if (pc_load) pl_n++;
        if (irq_ack) ack_n++;
        if (done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk({e.name, ".latency"}, cyc - e.t, e.lat);
            chk({e.name, ".ovf_err"}, ovf_err, e.ovf);
            chk({e.name, ".unf_err"}, unf_err, e.unf);
            chk({e.name, ".irq_ack"}, ack_n, e.ack);
            chk({e.name, ".mem_writes"}, mw_n, e.mw);
            if (e.mw) begin
              chk({e.name, ".mem_addr"}, o_ma, e.ma);
              chk({e.name, ".mem_wdata"}, o_md, e.md);
            end
            chk({e.name, ".sp_writes"}, spw_n, e.spw);
            if (e.spw) chk({e.name, ".sp_value"}, o_spv, e.spv);
            chk({e.name, ".reg_writes"}, rw_n, e.rw);
            if (e.rw) begin
              chk({e.name, ".reg_sel"}, o_ri, e.ri);
              chk({e.name, ".reg_data"}, o_rv, e.rv);
            end
            chk({e.name, ".pc_loads"}, pl_n, e.pl);
            if (e.pl) chk({e.name, ".pc_next"}, o_pn, e.pn);
          end
          mw_n = 0; spw_n = 0; rw_n = 0; pl_n = 0; ack_n = 0; rdy_chk = 1;
        end
      end
    end
  end

  task automatic wait_idle(input string n);
    int k = 0;
    @(negedge clk); #1;
    while (!cmd_ready && k < 50) begin @(negedge clk); #1; k++; end
    if (!cmd_ready) chk({n, ".idle_timeout"}, 0, 1);
  endtask

  task automatic poke(input bit is_mem, input logic [11:0] idx, input logic [15:0] val);
    wait_idle("poke");
    pk_en = 1; pk_mem = is_mem; pk_idx = idx; pk_val = val;
    @(posedge clk); #1;
    pk_en = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] r, input logic [11:0] tgt,
                       input logic [11:0] pc, input exp_t e, input bit track);
    int k = 0;
    @(negedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_reg = r; cmd_target = tgt; pc_in = pc;
    while (!cmd_ready && k < 50) begin @(negedge clk); #1; k++; end
    if (!cmd_ready) begin
      chk({e.name, ".accept_timeout"}, 0, 1);
      cmd_valid = 0;
      return;
    end
    e.t = cyc;
    if (track) sbq.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_ack(input string n);
    int k = 0;
    while (!irq_ack && k < 10) begin @(negedge clk); #1; k++; end
    if (!irq_ack) chk({n, ".ack_timeout"}, 0, 1);
    irq = 0;
  endtask

  task automatic irq_enter(input logic [11:0] isr, input logic [11:0] pc, input exp_t e);
    wait_idle(e.name);
    isr_in = isr; pc_in = pc; irq = 1;
    e.t = cyc;
    sbq.push_back(e);
    wait_ack(e.name);
  endtask

  initial begin
    exp_t e;
    int   k;
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_reg = 0; cmd_target = 0; pc_in = 0;
    irq = 0; isr_in = 0; pk_en = 0; pk_mem = 0; pk_idx = 0; pk_val = 0;
    cyc = 0; sp = 0; mem_rdata = 0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset.done", done, 0);
    chk("reset.mem_we", mem_we, 0);
    chk("reset.mem_re", mem_re, 0);
    chk("reset.rb_write_en", rb_write_en, 0);
    chk("reset.pc_load", pc_load, 0);
    chk("reset.irq_ack", irq_ack, 0);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset.cmd_ready", cmd_ready, 1);

    // PUSH / POP
    poke(0, 12'd3, 16'hBEEF);
    poke(0, 12'd8, 16'h0010);
    issue(2'b00, 3'd3, 12'h0, 12'h0,
          mk("push_r3", 1, 0, 0, 0, 1, 12'h00F, 16'hBEEF, 1, 12'h00F, 0, 0, 0, 0, 0), 1);
    poke(1, 12'h00F, 16'h1234);
    issue(2'b01, 3'd5, 12'h0, 12'h0,
          mk("pop_r5", 3, 0, 0, 0, 0, 0, 0, 1, 12'h010, 1, 3'd5, 16'h1234, 0, 0), 1);

    // CALL / RET
    poke(0, 12'd8, 16'h0100);
    issue(2'b10, 3'd0, 12'h300, 12'h042,
          mk("call", 1, 0, 0, 0, 1, 12'h0FF, 16'h0042, 1, 12'h0FF, 0, 0, 0, 1, 12'h300), 1);
    issue(2'b11, 3'd0, 12'h0, 12'h0,
          mk("ret", 2, 0, 0, 0, 0, 0, 0, 1, 12'h100, 0, 0, 0, 1, 12'h042), 1);

    // irq and PUSH offered together: irq first, PUSH after irq drops
    poke(0, 12'd1, 16'h1111);
    wait_idle("irq_vs_push");
    cmd_valid = 1; cmd_op = 2'b00; cmd_reg = 3'd1; isr_in = 12'h800; pc_in = 12'h055; irq = 1;
    e = mk("irq", 1, 0, 0, 1, 1, 12'h0FF, 16'h0055, 1, 12'h0FF, 0, 0, 0, 1, 12'h800);
    e.t = cyc;
    sbq.push_back(e);
    wait_ack("irq");
    issue(2'b00, 3'd1, 12'h0, 12'h055,
          mk("push_after_irq", 1, 0, 0, 0, 1, 12'h0FE, 16'h1111, 1, 12'h0FE, 0, 0, 0, 0, 0), 1);

    // Underflow / overflow
    poke(0, 12'd8, 16'h0000);
    issue(2'b01, 3'd2, 12'h0, 12'h0, mk("pop_unf", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    issue(2'b11, 3'd0, 12'h0, 12'h0, mk("ret_unf", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    poke(0, 12'd8, 16'h0F00);
    issue(2'b00, 3'd3, 12'h0, 12'h0, mk("push_ovf", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    issue(2'b10, 3'd0, 12'h123, 12'h7, mk("call_ovf", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    irq_enter(12'h800, 12'h009, mk("irq_ovf", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // SP edges: push down to 0, pop from 0xFFF wraps
    poke(0, 12'd2, 16'hA5A5);
    poke(0, 12'd8, 16'h0001);
    issue(2'b00, 3'd2, 12'h0, 12'h0,
          mk("push_to_zero", 1, 0, 0, 0, 1, 12'h000, 16'hA5A5, 1, 12'h000, 0, 0, 0, 0, 0), 1);
    poke(0, 12'd8, 16'h0FFF);
    poke(1, 12'hFFF, 16'h7777);
    issue(2'b01, 3'd7, 12'h0, 12'h0,
          mk("pop_wrap", 3, 0, 0, 0, 0, 0, 0, 1, 12'h000, 1, 3'd7, 16'h7777, 0, 0), 1);

    // Reset while in POP_WB drops the pending register and SP writes
    poke(0, 12'd8, 16'h000F);
    poke(1, 12'h00F, 16'h2222);
    poke(0, 12'd5, 16'h5555);
    issue(2'b01, 3'd5, 12'h0, 12'h0, mk("pop_reset", 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    chk("rst_mid.rb_write_en", rb_write_en, 0);
    chk("rst_mid.mem_re", mem_re, 0);
    chk("rst_mid.done", done, 0);
    repeat (2) @(negedge clk);
    chk("rst_mid.sp_kept", sp, 12'h00F);
    chk("rst_mid.r5_kept", regs[5], 16'h5555);
    #1 rst_n = 1;
    issue(2'b00, 3'd5, 12'h0, 12'h0,
          mk("push_after_rst", 1, 0, 0, 0, 1, 12'h00E, 16'h5555, 1, 12'h00E, 0, 0, 0, 0, 0), 1);

    k = 0;
    while (sbq.size() != 0 && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
